// File: rtl/ahb_master_arb.sv
`default_nettype none
// ============================================================================
// ahb_master_arb : AHB-Lite multi-master arbiter (IDLE/OWN/LOCK), registered
// grant. Optional round-robin via AHB_ARB_RR_EN.  Revision: 1.0
// ============================================================================
module ahb_master_arb #(
  parameter int NM = 3,
  parameter int MW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NM-1:0] hreq,
  input  logic [NM-1:0] hlock,
  input  logic [1:0]    htrans,
  input  logic          hready,
  output logic [NM-1:0] hgrant,
  output logic [MW-1:0] hmaster,
  output logic [MW-1:0] hmaster_d,
  output logic          hmastlock
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  state_e        state_q;
  logic [NM-1:0] hgrant_q;
  logic [MW-1:0] hmaster_q;
  logic [MW-1:0] hmdata_q;
  logic          mastlock_q;

  logic          w_win_valid;
  logic [MW-1:0] w_win_idx;
  logic          w_lock_keep;
  logic          w_xfer_bound;
  logic          w_arb_pt;
  int            w_idx;

`ifdef AHB_ARB_RR_EN
  logic [MW-1:0] ptr_q;
  logic [MW-1:0] ptr_d;
`endif

  // Winner search: descending loop so the lowest search offset is the final writer.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_idx       = 0;
    for (int k = NM - 1; k >= 0; k--) begin
`ifdef AHB_ARB_RR_EN
      w_idx = int'(ptr_q) + k;
      if (w_idx >= NM) w_idx = w_idx - NM;
`else
      w_idx = k;
`endif
      if (hreq[w_idx]) begin
        w_win_valid = 1'b1;
        w_win_idx   = MW'(w_idx);
      end
    end
  end

`ifdef AHB_ARB_RR_EN
  assign ptr_d = (w_win_idx == MW'(NM - 1)) ? '0 : w_win_idx + 1'b1;
`endif

  // A lock bit only counts while its master is also requesting.
  assign w_lock_keep  = hreq[hmaster_q] & hlock[hmaster_q];
  assign w_xfer_bound = (htrans == 2'b00) || (htrans == 2'b10);
  assign w_arb_pt     = (state_q == S_IDLE) ? 1'b1 :
                        (hready && w_xfer_bound &&
                         !((state_q == S_LOCK) && w_lock_keep));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hgrant_q   <= '0;
      hmaster_q  <= '0;
      hmdata_q   <= '0;
      mastlock_q <= 1'b0;
`ifdef AHB_ARB_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      if (hready) hmdata_q <= hmaster_q;
      if (w_arb_pt) begin
        if (w_win_valid) begin
          state_q    <= hlock[w_win_idx] ? S_LOCK : S_OWN;
          hgrant_q   <= NM'(1) << w_win_idx;
          hmaster_q  <= w_win_idx;
          mastlock_q <= hlock[w_win_idx];
`ifdef AHB_ARB_RR_EN
          ptr_q      <= ptr_d;
`endif
        end else begin
          // Nobody wants the bus: release it but remember the last owner index.
          state_q    <= S_IDLE;
          hgrant_q   <= '0;
          mastlock_q <= 1'b0;
        end
      end
    end
  end

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hmaster_d = hmdata_q;
  assign hmastlock = mastlock_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arb.sv
`default_nettype none
// ============================================================================
// tb_ahb_master_arb : directed + randomized bench with a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_ahb_master_arb;

  localparam int NM = 3;
  localparam int MW = 2;
`ifdef AHB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NM-1:0] hreq = '0;
  logic [NM-1:0] hlock = '0;
  logic [1:0]    htrans = 2'b00;
  logic          hready = 1'b1;
  logic [NM-1:0] hgrant;
  logic [MW-1:0] hmaster;
  logic [MW-1:0] hmaster_d;
  logic          hmastlock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_own  = 1'b0;
  int m_idx  = 0;
  bit m_lock = 1'b0;
  int m_ptr  = 0;
  int m_md   = 0;

  ahb_master_arb #(.NM(NM), .MW(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hreq      (hreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .hmastlock (hmastlock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic [NM-1:0] rq, input logic [NM-1:0] lk,
                              input logic [1:0] tr, input logic rdy, input logic rn);
    bit arb;
    int w;
    int c;
    if (!rn) begin
      m_own = 0; m_idx = 0; m_lock = 0; m_ptr = 0; m_md = 0;
    end else begin
      if (rdy) m_md = m_idx;
      if (!m_own) arb = 1'b1;
      else arb = rdy && (tr == 2'b00 || tr == 2'b10) && !(m_lock && rq[m_idx] && lk[m_idx]);
      if (arb) begin
        w = -1;
        for (int k = 0; k < NM; k++) begin
          c = ((RR ? m_ptr : 0) + k) % NM;
          if (rq[c] && w < 0) w = c;
        end
        if (w >= 0) begin
          m_own = 1; m_idx = w; m_lock = lk[w]; m_ptr = (w + 1) % NM;
        end else begin
          m_own = 0; m_lock = 0;
        end
      end
    end
  endtask

  task automatic step(input string tag, input logic [NM-1:0] rq, input logic [NM-1:0] lk,
                      input logic [1:0] tr, input logic rdy, input logic rn);
    logic [NM-1:0] eg;
    hreq = rq; hlock = lk; htrans = tr; hready = rdy; rst_n = rn;
    @(posedge clk);
    model_update(rq, lk, tr, rdy, rn);
    #1;
    eg = m_own ? (NM'(1) << m_idx) : '0;
    chk({tag, ".hgrant"},    32'(hgrant),    32'(eg));
    chk({tag, ".hmaster"},   32'(hmaster),   32'(m_idx));
    chk({tag, ".hmaster_d"}, 32'(hmaster_d), 32'(m_md));
    chk({tag, ".hmastlock"}, 32'(hmastlock), 32'(m_lock));
  endtask

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  initial begin
    logic [NM-1:0] rq;
    logic [1:0]    tr;
    logic          rdy;
    logic          rn;

    // Reset state
    step("rst0", 3'b000, 3'b000, T_IDLE, 1'b1, 1'b0);
    step("rst1", 3'b101, 3'b101, T_NSEQ, 1'b1, 1'b0);
    chk("rst.grant_zero", 32'(hgrant), 32'd0);

    // First grant from IDLE, lowest/first requester
    step("first", 3'b110, 3'b000, T_IDLE, 1'b1, 1'b1);
    chk("first.grant", 32'(hgrant), 32'b010);
    chk("first.master", 32'(hmaster), 32'd1);

    // Burst on owner 1: SEQ/BUSY/wait cycles never move the grant
    step("burst.b2", 3'b101, 3'b000, T_SEQ,  1'b1, 1'b1);
    step("burst.b2w", 3'b101, 3'b000, T_SEQ, 1'b0, 1'b1);
    step("burst.b3", 3'b101, 3'b000, T_BUSY, 1'b1, 1'b1);
    step("burst.b4", 3'b101, 3'b000, T_SEQ,  1'b1, 1'b1);
    chk("burst.held", 32'(hmaster), 32'd1);
    step("burst.end", 3'b101, 3'b000, T_IDLE, 1'b1, 1'b1);
    chk("burst.next", 32'(hmaster), RR ? 32'd2 : 32'd0);

    // All requesting, NONSEQ every cycle: rotation (RR) or master 0 (fixed)
    step("rot.rst", 3'b000, 3'b000, T_IDLE, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("rot", 3'b111, 3'b000, T_NSEQ, 1'b1, 1'b1);
      chk("rot.seq", 32'(hmaster), RR ? 32'(i % NM) : 32'd0);
    end

    // Locked master 2 keeps the bus until it drops hlock
    step("lk.rst", 3'b000, 3'b000, T_IDLE, 1'b1, 1'b0);
    step("lk.get", 3'b100, 3'b100, T_IDLE, 1'b1, 1'b1);
    chk("lk.mastlock", 32'(hmastlock), 32'd1);
    for (int i = 0; i < 3; i++) step("lk.hold", 3'b111, 3'b100, T_NSEQ, 1'b1, 1'b1);
    chk("lk.held", 32'(hmaster), 32'd2);
    step("lk.rel", 3'b111, 3'b000, T_NSEQ, 1'b1, 1'b1);
    chk("lk.unlocked", 32'(hmastlock), 32'd0);

    // Data-phase index lags through wait states
    step("dp.own0", 3'b001, 3'b000, T_NSEQ, 1'b1, 1'b1);
    step("dp.chg", 3'b110, 3'b000, T_NSEQ, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("dp.wait", 3'b110, 3'b000, T_SEQ, 1'b0, 1'b1);
    chk("dp.old", 32'(hmaster_d), 32'd0);
    step("dp.load", 3'b110, 3'b000, T_SEQ, 1'b1, 1'b1);
    chk("dp.new", 32'(hmaster_d), 32'd1);

    // Owner drops while another asserts; then full release to IDLE
    step("swap", 3'b100, 3'b000, T_IDLE, 1'b1, 1'b1);
    chk("swap.master", 32'(hmaster), 32'd2);
    step("rel", 3'b000, 3'b000, T_IDLE, 1'b1, 1'b1);
    chk("rel.grant", 32'(hgrant), 32'd0);
    chk("rel.master_hold", 32'(hmaster), 32'd2);

    // Reset during LOCK
    step("rl.get", 3'b001, 3'b001, T_NSEQ, 1'b1, 1'b1);
    step("rl.rst", 3'b001, 3'b001, T_SEQ, 1'b0, 1'b0);
    chk("rl.zero", 32'({hgrant, hmaster, hmaster_d, hmastlock}), 32'd0);
    step("rl.after", 3'b001, 3'b000, T_IDLE, 1'b1, 1'b1);
    chk("rl.grant", 32'(hgrant), 32'b001);

    // Randomized traffic; lock bits only on requesting masters
    for (int i = 0; i < 400; i++) begin
      rq  = NM'($urandom_range(0, (1 << NM) - 1));
      tr  = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) != 0);
      rn  = ($urandom_range(0, 39) != 0);
      step("rnd", rq, rq & NM'($urandom_range(0, (1 << NM) - 1)), tr, rdy, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
